// File: rtl/dispatch.sv
// dispatch: rename -> ALU/LSU/BRU reservation-station dispatch with preg ready table.
// Define DISPATCH_STATS_EN to add the stat_dispatched / stat_stall counters.
package dispatch_pkg;
    localparam int NUM_PREGS = 128;
    localparam int PREG_W    = 7;
    localparam int ROB_W     = 4;

    typedef struct packed {
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
        logic [31:0]       imm;
        logic [ROB_W-1:0]  rob_index;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
    } rename_instr_t;

    typedef struct packed {
        logic [PREG_W-1:0] prd;
        logic [PREG_W-1:0] pr1;
        logic [PREG_W-1:0] pr2;
        logic [31:0]       imm;
        logic [ROB_W-1:0]  rob_index;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic              pr1_ready;
        logic              pr2_ready;
    } dispatch_pipeline_data_t;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BRU = 2'd2
    } fu_sel_t;
endpackage

module dispatch
    import dispatch_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  rename_instr_t           in_instr,
    output logic                    alu_valid,
    output logic                    lsu_valid,
    output logic                    bru_valid,
    input  logic                    alu_ready,
    input  logic                    lsu_ready,
    input  logic                    bru_ready,
    output dispatch_pipeline_data_t out_instr,
    input  logic [PREG_W-1:0]       reg1_rdy,
    input  logic [PREG_W-1:0]       reg2_rdy,
    input  logic [PREG_W-1:0]       reg3_rdy,
    input  logic                    reg1_rdy_valid,
    input  logic                    reg2_rdy_valid,
    input  logic                    reg3_rdy_valid,
`ifdef DISPATCH_STATS_EN
    output logic [31:0]             stat_dispatched,
    output logic [31:0]             stat_stall,
`endif
    output logic [PREG_W-1:0]       nr_reg,
    output logic                    nr_valid
);

    logic [NUM_PREGS-1:0]    rdy_tbl;
    logic [NUM_PREGS-1:0]    tbl_next;
    logic                    hold_valid;
    fu_sel_t                 fu_sel;
    fu_sel_t                 cap_sel;
    logic                    sel_ready;
    logic                    accept;
    logic                    leave;
    logic                    alloc;
    dispatch_pipeline_data_t cap;
    dispatch_pipeline_data_t held_next;

    function automatic logic bcast_hit(input logic [PREG_W-1:0] p);
        return (reg1_rdy_valid && reg1_rdy == p)
            || (reg2_rdy_valid && reg2_rdy == p)
            || (reg3_rdy_valid && reg3_rdy == p);
    endfunction

    function automatic logic src_ready(input logic [PREG_W-1:0] p);
        return (p == '0) || rdy_tbl[p] || bcast_hit(p);
    endfunction

    always_comb begin
        sel_ready = 1'b0;
        unique case (fu_sel)
            FU_ALU:  sel_ready = alu_ready;
            FU_LSU:  sel_ready = lsu_ready;
            FU_BRU:  sel_ready = bru_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    assign in_ready  = !hold_valid || sel_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign leave     = hold_valid && sel_ready;
    assign alloc     = accept && (in_instr.prd != '0);

    assign alu_valid = hold_valid && (fu_sel == FU_ALU);
    assign lsu_valid = hold_valid && (fu_sel == FU_LSU);
    assign bru_valid = hold_valid && (fu_sel == FU_BRU);

    always_comb begin
        cap_sel = FU_ALU;
        unique case (1'b1)
            (in_instr.opcode == 7'h03),
            (in_instr.opcode == 7'h23): cap_sel = FU_LSU;
            (in_instr.opcode == 7'h63),
            (in_instr.opcode == 7'h6F),
            (in_instr.opcode == 7'h67): cap_sel = FU_BRU;
            default:                    cap_sel = FU_ALU;
        endcase
    end

    always_comb begin
        cap           = '0;
        cap.prd       = in_instr.prd;
        cap.pr1       = in_instr.pr1;
        cap.pr2       = in_instr.pr2;
        cap.imm       = in_instr.imm;
        cap.rob_index = in_instr.rob_index;
        cap.opcode    = in_instr.opcode;
        cap.func3     = in_instr.func3;
        cap.func7     = in_instr.func7;
        cap.pr1_ready = src_ready(in_instr.pr1);
        cap.pr2_ready = src_ready(in_instr.pr2);
    end

    // Held entry only ever gains readiness from wakeups.
    always_comb begin
        held_next = out_instr;
        if (hold_valid) begin
            held_next.pr1_ready = out_instr.pr1_ready || bcast_hit(out_instr.pr1);
            held_next.pr2_ready = out_instr.pr2_ready || bcast_hit(out_instr.pr2);
        end
    end

    // Dispatch clear of prd is applied last so it wins over a same-edge broadcast.
    always_comb begin
        tbl_next = rdy_tbl;
        if (reg1_rdy_valid) tbl_next[reg1_rdy] = 1'b1;
        if (reg2_rdy_valid) tbl_next[reg2_rdy] = 1'b1;
        if (reg3_rdy_valid) tbl_next[reg3_rdy] = 1'b1;
        if (alloc)          tbl_next[in_instr.prd] = 1'b0;
        tbl_next[0] = 1'b1;
        if (flush)          tbl_next = '1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_tbl    <= '1;
            hold_valid <= 1'b0;
            fu_sel     <= FU_ALU;
            out_instr  <= '0;
            nr_reg     <= '0;
            nr_valid   <= 1'b0;
        end else begin
            rdy_tbl  <= tbl_next;
            nr_valid <= alloc;
            if (alloc) nr_reg <= in_instr.prd;
            if (flush) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                fu_sel     <= cap_sel;
                out_instr  <= cap;
            end else begin
                if (leave) hold_valid <= 1'b0;
                out_instr <= held_next;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_dispatched <= '0;
            stat_stall      <= '0;
        end else begin
            if (leave)                    stat_dispatched <= stat_dispatched + 32'd1;
            if (hold_valid && !sel_ready) stat_stall      <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dispatch.md
# dispatch

Dispatch stage that sits between rename and the three reservation stations (ALU, LSU, BRU). It accepts one renamed instruction per cycle and looks up source-operand readiness in an internal 128-entry physical-register ready table. It routes the instruction through a single holding register to the correct RS using the valid/ready handshake. It also drives the not-ready notification for the newly allocated destination register.

## Interface
- NUM_PREGS, 128, physical registers (index width 7)
- ROB_W, 4, ROB index width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- flush  in  1  full-pipeline squash
- in_valid  in  1  rename has an instruction
- in_ready  out  1  dispatch can accept this cycle
- in_instr  in  struct  renamed instruction: prd, pr1, pr2 (7 each), imm (32), rob_index (ROB_W), Opcode (7), func3 (3), func7 (7)
- alu_valid / lsu_valid / bru_valid  out  1 each  instruction offered to that RS
- alu_ready / lsu_ready / bru_ready  in  1 each  RS can accept
- out_instr  out  struct  dispatch_pipeline_data, shared by all three RSs; pr1_ready/pr2_ready filled in
- nr_reg  out  7  destination preg being marked not-ready
- nr_valid  out  1  nr_reg is valid
- reg1_rdy, reg2_rdy, reg3_rdy  in  7 each  wakeup broadcasts
- reg1_rdy_valid, reg2_rdy_valid, reg3_rdy_valid  in  1 each  broadcast valid

## Operation
- Ready table: 128 bits. 1 = value available.
- Reset: all table bits are 1. hold_valid=0, all *_valid=0, nr_valid=0, nr_reg=0, out_instr=0.
- in_ready = !hold_valid || sel_ready, where sel_ready is the ready input of the RS targeted by the held entry. in_ready is combinational and does not depend on in_valid.
- Accept occurs when in_valid && in_ready && !flush. On accept, the hold register captures in_instr and the FU select.
- Captured pr1_ready = table[pr1] OR a match against any valid same-cycle broadcast. pr2_ready is computed the same way.
- Preg 0 always reads ready and is never cleared.
- FU select by Opcode:
  - 0x03 and 0x23 → LSU.
  - 0x63, 0x6F and 0x67 → BRU.
  - Everything else, including 0x33, 0x13, 0x37, 0x17 and unknown opcodes → ALU.
- On accept with prd≠0:
  - Next cycle, nr_reg=prd and nr_valid=1 for exactly one cycle.
  - table[prd] is cleared at the accept edge.
- Table update priority within one edge:
  - The dispatch clear of prd beats a same-cycle broadcast set of the same preg.
  - Broadcasts set all other matched bits.
  - Duplicate broadcasts of the same preg are harmless.
- Held-entry wakeup: while hold_valid, any valid broadcast matching the held pr1/pr2 sets the held ready bit. The bit is never cleared while held.
- Exactly one of alu/lsu/bru_valid equals hold_valid; the other two are 0.
- The held entry leaves when its sel_ready=1. A new entry may be captured on the same edge (back-to-back, full throughput).
- Flush:
  - hold_valid is cleared and nr_valid is forced to 0 next cycle.
  - All table bits are set to 1; all in-flight instructions are squashed.
  - in_ready is still computed normally, but no accept occurs during flush.
- Reset mid-operation drops the held entry immediately (asynchronous). No output pulse follows.

## Timing
- Latency: accept edge N → *_valid and nr_valid high in cycle N+1.
- An entry stalls indefinitely while its RS is not ready. out_instr is stable while stalled, except that ready bits may rise due to wakeup.
- Consumer sees pr1_ready=1 if a broadcast matched at the accept edge or at any edge while held.
- Stall cycle: in_ready=0 when hold_valid && !sel_ready.

## Configuration
- DISPATCH_STATS_EN defined:
  - Adds outputs stat_dispatched[31:0], incremented on every RS handshake.
  - Adds stat_stall[31:0], incremented each cycle with hold_valid && !sel_ready.
  - Both counters clear on reset, do not clear on flush, and wrap modulo 2^32.
- DISPATCH_STATS_EN undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Test plan
- Reset, then send prd=10, pr1=1, pr2=2, Opcode 0x33 with all RS ready:
  - alu_valid=1 one cycle later, pr1_ready=pr2_ready=1.
  - nr_valid=1 with nr_reg=10.
- Send instr A with prd=11, then instr B with pr1=11:
  - B is dispatched with pr1_ready=0.
  - reg2_rdy=11 with valid while B is held and lsu_ready=0 → B's pr1_ready rises to 1 before the handshake.
- Opcode 0x23 with lsu_ready=0 for 4 cycles:
  - lsu_valid held high for 4 cycles, in_ready=0 throughout, out_instr stable.
  - Handshake on cycle 5; next accept happens on the same edge.
- Same-cycle broadcast reg1_rdy=5 while accepting pr1=5 (table bit 0) → captured pr1_ready=1.
- Same-cycle broadcast reg1_rdy=20 while accepting prd=20 → table[20]=0 afterwards.
- Flush while an entry is held → all *_valid=0 next cycle. A subsequent instr with pr1=10 dispatches with pr1_ready=1.
